// File: rtl/axil_pattern_pkg.sv
// Shared encodings for the AXI4-Lite pattern filler: fill modes, sequencing
// FSM states and AXI response codes.
package axil_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BLOCK_ID = 2'd0,
        MODE_WORD_IDX = 2'd1,
        MODE_CONST    = 2'd2,
        MODE_NOT_IDX  = 2'd3
    } fill_mode_e;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_WR_ADDR     = 4'd1,
        S_WR_RESP     = 4'd2,
        S_RD_ADDR     = 4'd3,
        S_RD_DATA     = 4'd4,
        S_NEXT        = 4'd5,
        S_NOTIFY      = 4'd6,
        S_NOTIFY_RESP = 4'd7,
        S_FIN         = 4'd8
    } fill_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_lite_master_core.sv
// Single-transaction AXI4-Lite master engine. Address and write data are
// passed straight through from the caller, who holds them stable for the
// whole transaction; this block only owns the VALID/READY handshakes.
module axil_lite_master_core
    import axil_pattern_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_start,
    input  logic                    rd_start,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    wr_addr_done,
    output logic                    rd_addr_done,
    output logic                    resp_valid,
    output logic [1:0]              resp,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    output logic [2:0]              m_axi_awprot,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    output logic [2:0]              m_axi_arprot,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    assign m_axi_awaddr = addr;
    assign m_axi_araddr = addr;
    assign m_axi_wdata  = wdata;
    assign m_axi_wstrb  = '1;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b001;

    // Address and data phases are "done" once neither channel still waits.
    assign wr_addr_done = (!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready);
    assign rd_addr_done = m_axi_arvalid && m_axi_arready;
    assign resp_valid   = (m_axi_bready && m_axi_bvalid) || (m_axi_rready && m_axi_rvalid);
    assign resp         = m_axi_bready ? m_axi_bresp : m_axi_rresp;
    assign rdata        = m_axi_rdata;

    // Each VALID/READY flag rises on its start command and drops on its own handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            if (wr_start) begin
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                m_axi_bready  <= 1'b1;
            end else begin
                if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                if (m_axi_bvalid && m_axi_bready)   m_axi_bready  <= 1'b0;
            end
            if (rd_start) begin
                m_axi_arvalid <= 1'b1;
                m_axi_rready  <= 1'b1;
            end else begin
                if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
                if (m_axi_rvalid && m_axi_rready)   m_axi_rready  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axil_pattern_filler.sv
// AXI4-Lite master that fills BLOCKS x WORDS_PER_BLOCK words with a pattern,
// then writes CTL_VALUE to CTL_ADDR when every write succeeded.
// Optional read-back check: define AXIL_PATTERN_VERIFY_EN.
//
// state         | meaning
// S_IDLE        | waiting for start, inputs latched on start
// S_WR_ADDR     | AW and W in flight for the current word
// S_WR_RESP     | waiting for the B response of the current word
// S_RD_ADDR     | read-back AR in flight (verify builds only)
// S_RD_DATA     | waiting for read-back data (verify builds only)
// S_NEXT        | advance word/block counters or finish the region
// S_NOTIFY      | AW/W of the notify write in flight
// S_NOTIFY_RESP | waiting for the notify B response
// S_FIN         | done pulse visible, returning to idle
module axil_pattern_filler
    import axil_pattern_pkg::*;
#(
    parameter int unsigned                 AXI_DATA_WIDTH  = 32,
    parameter int unsigned                 AXI_ADDR_WIDTH  = 32,
    parameter int unsigned                 BLOCKS          = 512,
    parameter int unsigned                 WORDS_PER_BLOCK = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0]   CTL_ADDR        = 'h0000_1014,
    parameter logic [AXI_DATA_WIDTH-1:0]   CTL_VALUE       = 'h42
) (
    input  logic                        M_AXI_ACLK,
    input  logic                        M_AXI_ARESETN,
    input  logic                        start,
    input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
    input  logic [1:0]                  mode,
    input  logic [AXI_DATA_WIDTH-1:0]   const_word,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [15:0]                 err_count,
    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                        M_AXI_AWVALID,
    output logic [2:0]                  M_AXI_AWPROT,
    input  logic                        M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    output logic [2:0]                  M_AXI_ARPROT,
    input  logic                        M_AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    localparam logic [31:0] TOTAL_M1 = 32'(BLOCKS) * 32'(WORDS_PER_BLOCK) - 32'd1;
    localparam logic [15:0] WPB_M1   = 16'(WORDS_PER_BLOCK - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

    fill_state_e                 state;
    fill_mode_e                  mode_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   const_q;
    logic [31:0]                 word_idx;
    logic [31:0]                 words_left;
    logic [15:0]                 blk_left;
    logic [7:0]                  block_id;
    logic [AXI_DATA_WIDTH-1:0]   pattern_word;
    logic                        notify_phase;
    logic                        issue_wr;
    logic                        issue_rd;
    logic                        word_fail;
    logic                        core_wr_addr_done;
    logic                        core_rd_addr_done;
    logic                        core_resp_valid;
    logic [1:0]                  core_resp;
    logic [AXI_DATA_WIDTH-1:0]   core_rdata;
    logic [AXI_ADDR_WIDTH-1:0]   core_addr;
    logic [AXI_DATA_WIDTH-1:0]   core_wdata;

    // Pattern for the current word; stable for the whole write and read-back.
    always_comb begin
        pattern_word = '0;
        case (mode_q)
            MODE_BLOCK_ID: pattern_word = {(AXI_DATA_WIDTH/8){block_id}};
            MODE_WORD_IDX: pattern_word = AXI_DATA_WIDTH'(word_idx);
            MODE_CONST:    pattern_word = const_q;
            MODE_NOT_IDX:  pattern_word = ~AXI_DATA_WIDTH'(word_idx);
            default:       pattern_word = '0;
        endcase
    end

    assign notify_phase = (state == S_NOTIFY) || (state == S_NOTIFY_RESP);
    assign core_addr    = notify_phase ? CTL_ADDR : addr_q;
    assign core_wdata   = notify_phase ? CTL_VALUE : pattern_word;

    // Commands fire on the same edge that moves the FSM into the matching phase.
    assign issue_wr = ((state == S_IDLE) && start) ||
                      ((state == S_NEXT) && ((words_left != 32'd0) || !error));
`ifdef AXIL_PATTERN_VERIFY_EN
    assign issue_rd = (state == S_WR_RESP) && core_resp_valid;
`else
    assign issue_rd = 1'b0;
`endif

    assign word_fail = core_resp_valid &&
                       ((core_resp != AXI_RESP_OKAY) ||
                        ((state == S_RD_DATA) && (core_rdata != pattern_word)));

    axil_lite_master_core #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .ADDR_WIDTH (AXI_ADDR_WIDTH)
    ) u_core (
        .clk           (M_AXI_ACLK),
        .rst_n         (M_AXI_ARESETN),
        .wr_start      (issue_wr),
        .rd_start      (issue_rd),
        .addr          (core_addr),
        .wdata         (core_wdata),
        .wr_addr_done  (core_wr_addr_done),
        .rd_addr_done  (core_rd_addr_done),
        .resp_valid    (core_resp_valid),
        .resp          (core_resp),
        .rdata         (core_rdata),
        .m_axi_awaddr  (M_AXI_AWADDR),
        .m_axi_awvalid (M_AXI_AWVALID),
        .m_axi_awprot  (M_AXI_AWPROT),
        .m_axi_awready (M_AXI_AWREADY),
        .m_axi_wdata   (M_AXI_WDATA),
        .m_axi_wstrb   (M_AXI_WSTRB),
        .m_axi_wvalid  (M_AXI_WVALID),
        .m_axi_wready  (M_AXI_WREADY),
        .m_axi_bresp   (M_AXI_BRESP),
        .m_axi_bvalid  (M_AXI_BVALID),
        .m_axi_bready  (M_AXI_BREADY),
        .m_axi_araddr  (M_AXI_ARADDR),
        .m_axi_arvalid (M_AXI_ARVALID),
        .m_axi_arprot  (M_AXI_ARPROT),
        .m_axi_arready (M_AXI_ARREADY),
        .m_axi_rdata   (M_AXI_RDATA),
        .m_axi_rresp   (M_AXI_RRESP),
        .m_axi_rvalid  (M_AXI_RVALID),
        .m_axi_rready  (M_AXI_RREADY)
    );

    // Sequencing FSM with word/block down-counters and registered status outputs.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state      <= S_IDLE;
            mode_q     <= MODE_BLOCK_ID;
            addr_q     <= '0;
            const_q    <= '0;
            word_idx   <= '0;
            words_left <= '0;
            blk_left   <= '0;
            block_id   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_count  <= '0;
        end else begin
            done <= 1'b0;
            if (word_fail) begin
                error <= 1'b1;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q     <= fill_mode_e'(mode);
                        addr_q     <= base_addr;
                        const_q    <= const_word;
                        word_idx   <= '0;
                        words_left <= TOTAL_M1;
                        blk_left   <= WPB_M1;
                        block_id   <= '0;
                        error      <= 1'b0;
                        err_count  <= '0;
                        busy       <= 1'b1;
                        state      <= S_WR_ADDR;
                    end
                end
                S_WR_ADDR: if (core_wr_addr_done) state <= S_WR_RESP;
                S_WR_RESP: begin
                    if (core_resp_valid) begin
`ifdef AXIL_PATTERN_VERIFY_EN
                        state <= S_RD_ADDR;
`else
                        state <= S_NEXT;
`endif
                    end
                end
                S_RD_ADDR: if (core_rd_addr_done) state <= S_RD_DATA;
                S_RD_DATA: if (core_resp_valid) state <= S_NEXT;
                S_NEXT: begin
                    if (words_left == 32'd0) begin
                        if (error) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FIN;
                        end else begin
                            state <= S_NOTIFY;
                        end
                    end else begin
                        word_idx   <= word_idx + 32'd1;
                        words_left <= words_left - 32'd1;
                        addr_q     <= addr_q + ADDR_STEP;
                        if (blk_left == 16'd0) begin
                            blk_left <= WPB_M1;
                            block_id <= block_id + 8'd1;
                        end else begin
                            blk_left <= blk_left - 16'd1;
                        end
                        state <= S_WR_ADDR;
                    end
                end
                S_NOTIFY: if (core_wr_addr_done) state <= S_NOTIFY_RESP;
                S_NOTIFY_RESP: begin
                    if (core_resp_valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FIN;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_pattern_filler.sv
// Directed bench for axil_pattern_filler with a small reactive AXI4-Lite slave.
module tb_axil_pattern_filler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [1:0]  mode = '0;
    logic [31:0] const_word = '0;
    logic        busy, done, error;
    logic [15:0] err_count;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axil_pattern_filler #(
        .AXI_DATA_WIDTH (32),
        .AXI_ADDR_WIDTH (32),
        .BLOCKS         (2),
        .WORDS_PER_BLOCK(4),
        .CTL_ADDR       (32'h0000_1014),
        .CTL_VALUE      (32'h42)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .start(start), .base_addr(base_addr),
        .mode(mode), .const_word(const_word), .busy(busy), .done(done), .error(error),
        .err_count(err_count),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWPROT(awprot), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARPROT(arprot), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    // Slave model: optional AW/W skew, injected BRESP error, corrupted read data.
    int          aw_n = 0, w_n = 0, b_n = 0, r_n = 0;
    int          aw_cnt = 0, w_cnt = 0;
    logic [31:0] aw_log [0:255];
    logic [31:0] w_log  [0:255];
    logic        pend_aw = 1'b0, pend_w = 1'b0;
    logic [31:0] w_last = '0;
    bit          skew = 1'b0;
    int          bad_b_idx = -1;
    int          corrupt_r_idx = -1;
    int          aw_del, w_del;

    assign aw_del  = skew ? (aw_n[0] ? 0 : 3) : 0;
    assign w_del   = skew ? (w_n[0] ? 3 : 0) : 0;
    assign awready = awvalid && (aw_cnt >= aw_del);
    assign wready  = wvalid && (w_cnt >= w_del);
    assign arready = 1'b1;
    assign rresp   = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            rvalid  <= 1'b0;
            rdata   <= '0;
            pend_aw <= 1'b0;
            pend_w  <= 1'b0;
            aw_cnt  <= 0;
            w_cnt   <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (awvalid && awready) begin
                aw_log[aw_n[7:0]] <= awaddr;
                aw_n <= aw_n + 1;
            end
            if (wvalid && wready) begin
                w_log[w_n[7:0]] <= wdata;
                w_n    <= w_n + 1;
                w_last <= wdata;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (!bvalid && (pend_aw || (awvalid && awready)) && (pend_w || (wvalid && wready))) begin
                bvalid  <= 1'b1;
                bresp   <= (b_n == bad_b_idx) ? 2'b10 : 2'b00;
                b_n     <= b_n + 1;
                pend_aw <= 1'b0;
                pend_w  <= 1'b0;
            end else begin
                if (awvalid && awready) pend_aw <= 1'b1;
                if (wvalid && wready)   pend_w  <= 1'b1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= w_last ^ ((r_n == corrupt_r_idx) ? 32'h0000_0100 : 32'h0);
                r_n    <= r_n + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One run: pulse start, optionally poke start while busy, wait bounded for done.
    task automatic run_fill(input string tag, input logic [31:0] base, input logic [1:0] md,
                            input logic [31:0] cw, input bit poke);
        bit got_done;
        @(negedge clk);
        base_addr = base; mode = md; const_word = cw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        got_done = 1'b0;
        for (int i = 0; i < 400 && !got_done; i++) begin
            @(negedge clk);
            start = poke && (i == 5);
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    int aw0, w0, r0;
    logic [31:0] exp_d;
    bit seen_aw;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0, block id replicated per byte
        aw0 = aw_n; w0 = w_n; r0 = r_n;
        run_fill("m0", 32'hC000_0000, 2'd0, 32'h0, 1'b0);
        chk("m0_aw_count", 32'(aw_n - aw0), 32'd9);
        chk("m0_w_count", 32'(w_n - w0), 32'd9);
        for (int k = 0; k < 8; k++) begin
            exp_d = (k < 4) ? 32'h0000_0000 : 32'h0101_0101;
            chk($sformatf("m0_addr%0d", k), aw_log[8'(aw0 + k)], 32'hC000_0000 + 32'(4 * k));
            chk($sformatf("m0_data%0d", k), w_log[8'(w0 + k)], exp_d);
        end
        chk("m0_notify_addr", aw_log[8'(aw0 + 8)], 32'h0000_1014);
        chk("m0_notify_data", w_log[8'(w0 + 8)], 32'h0000_0042);
        chk("m0_error", 32'(error), 32'd0);
        chk("m0_err_count", 32'(err_count), 32'd0);
`ifdef AXIL_PATTERN_VERIFY_EN
        chk("m0_reads", 32'(r_n - r0), 32'd8);
`else
        chk("m0_no_reads", 32'(r_n - r0), 32'd0);
`endif

        // Skewed AW/W handshakes, constant pattern, start poked while busy
        skew = 1'b1;
        aw0 = aw_n; w0 = w_n;
        run_fill("skew", 32'h0000_0100, 2'd2, 32'hDEAD_BEEF, 1'b1);
        skew = 1'b0;
        chk("skew_aw_count", 32'(aw_n - aw0), 32'd9);
        chk("skew_w_count", 32'(w_n - w0), 32'd9);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("skew_addr%0d", k), aw_log[8'(aw0 + k)], 32'h0000_0100 + 32'(4 * k));
            chk($sformatf("skew_data%0d", k), w_log[8'(w0 + k)], 32'hDEAD_BEEF);
        end
        chk("skew_notify_addr", aw_log[8'(aw0 + 8)], 32'h0000_1014);

        // BRESP SLVERR on word 5 of 8, mode 3 (~index)
        aw0 = aw_n; w0 = w_n;
        bad_b_idx = b_n + 4;
        run_fill("berr", 32'h0000_2000, 2'd3, 32'h0, 1'b0);
        bad_b_idx = -1;
        chk("berr_error", 32'(error), 32'd1);
        chk("berr_err_count", 32'(err_count), 32'd1);
        chk("berr_aw_count_no_notify", 32'(aw_n - aw0), 32'd8);
        chk("berr_data0", w_log[8'(w0)], 32'hFFFF_FFFF);
        chk("berr_data5", w_log[8'(w0 + 5)], 32'hFFFF_FFFA);
        chk("berr_addr7", aw_log[8'(aw0 + 7)], 32'h0000_201C);
        chk("berr_data7", w_log[8'(w0 + 7)], 32'hFFFF_FFF8);

        // Mode 1 with address wrap; error/err_count cleared by the new start
        aw0 = aw_n; w0 = w_n;
        run_fill("wrap", 32'hFFFF_FFF8, 2'd1, 32'h0, 1'b0);
        chk("wrap_addr0", aw_log[8'(aw0)], 32'hFFFF_FFF8);
        chk("wrap_addr1", aw_log[8'(aw0 + 1)], 32'hFFFF_FFFC);
        chk("wrap_addr2", aw_log[8'(aw0 + 2)], 32'h0000_0000);
        chk("wrap_addr3", aw_log[8'(aw0 + 3)], 32'h0000_0004);
        for (int k = 0; k < 4; k++)
            chk($sformatf("wrap_data%0d", k), w_log[8'(w0 + k)], 32'(k));
        chk("wrap_error_cleared", 32'(error), 32'd0);
        chk("wrap_err_count_cleared", 32'(err_count), 32'd0);

        // Reset while AWVALID is held mid-run
        skew = 1'b1;
        aw0 = aw_n;
        @(negedge clk);
        base_addr = 32'h0000_3000; mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_aw = 1'b0;
        for (int i = 0; i < 200 && !seen_aw; i++) begin
            @(negedge clk);
            if (awvalid && (aw_n - aw0) >= 2) seen_aw = 1'b1;
        end
        chk("rstmid_reached", 32'(seen_aw), 32'd1);
        chk("rstmid_awprot", 32'(awprot), 32'd0);
        chk("rstmid_wstrb", 32'(wstrb), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        skew = 1'b0;
        aw0 = aw_n; w0 = w_n;
        run_fill("rerun", 32'h0000_3000, 2'd0, 32'h0, 1'b0);
        chk("rerun_aw_count", 32'(aw_n - aw0), 32'd9);
        chk("rerun_addr0", aw_log[8'(aw0)], 32'h0000_3000);
        chk("rerun_data0", w_log[8'(w0)], 32'h0000_0000);
        chk("rerun_data7", w_log[8'(w0 + 7)], 32'h0101_0101);
        chk("rerun_notify", aw_log[8'(aw0 + 8)], 32'h0000_1014);

`ifdef AXIL_PATTERN_VERIFY_EN
        // Read-back of word 2 corrupted
        aw0 = aw_n;
        corrupt_r_idx = r_n + 2;
        run_fill("vfy", 32'h0000_4000, 2'd1, 32'h0, 1'b0);
        corrupt_r_idx = -1;
        chk("vfy_error", 32'(error), 32'd1);
        chk("vfy_err_count", 32'(err_count), 32'd1);
        chk("vfy_no_notify", 32'(aw_n - aw0), 32'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
